taylor_core_scheduler: RTL

Sequencer and result arbiter for a bank of N_CORES rede_taylor cores sharing one io_in sample stream.
- Releases each core's reset in turn, STAGGER cycles apart, so the cores run phase-offset.
- Latches every core result (data plus out_en tag) into a per-core holding slot.
- Drains those slots round-robin through a single valid/ready output port.
- Replaces the fixed-priority output mux, which silently drops results when two cores fire in the same cycle.

---
 rtl/taylor_core_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/taylor_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : taylor_core_scheduler
// Brief    : Staggered reset release for a bank of rede_taylor cores plus a
//            per-core result holding slot drained round-robin to one port.
// Revision : 1.0  initial release
// ============================================================================
module taylor_core_scheduler #(
    parameter int N_CORES = 33,
    parameter int DATA_W  = 28,
    parameter int TAG_W   = 4,
    parameter int IDX_W   = 6,
    parameter int STAGGER = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [N_CORES-1:0]         core_rst,
    input  logic [N_CORES*DATA_W-1:0]  core_data,
    input  logic [N_CORES*TAG_W-1:0]   core_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [IDX_W-1:0]           out_core,
    output logic                       overflow,
    output logic                       all_running
);

    localparam int c_CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic                 w_rel;
    logic [IDX_W-1:0]     w_rel_idx;
    logic                 r_all_running, w_all_nxt;
    logic [N_CORES-1:0]   r_core_rst;

    logic [N_CORES-1:0]   r_pending;
    logic [N_CORES-1:0]   w_cap;
    logic [N_CORES-1:0]   w_drain;
    logic [DATA_W-1:0]    r_hold_data [N_CORES];
    logic [TAG_W-1:0]     r_hold_tag  [N_CORES];

    logic                 w_load;
    logic                 w_found;
    logic [IDX_W-1:0]     w_grant;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [IDX_W-1:0]     r_ptr;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_data;
    logic [TAG_W-1:0]     r_out_tag;
    logic [IDX_W-1:0]     r_out_core;
    logic                 r_overflow;

    // ---------------- release sequencer ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rel       = 1'b0;
        w_rel_idx   = r_idx;
        w_all_nxt   = r_all_running;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rel     = 1'b1;
                    w_rel_idx = '0;
                    w_idx_nxt = '0;
                    w_cnt_nxt = '0;
                    if (N_CORES == 1) begin
                        w_state_nxt = S_RUN;
                        w_all_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (r_cnt == c_CNT_W'(STAGGER - 1)) begin
                    w_cnt_nxt = '0;
                    w_rel     = 1'b1;
                    w_rel_idx = r_idx + IDX_W'(1);
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx + IDX_W'(1) == IDX_W'(N_CORES - 1)) begin
                        w_state_nxt = S_RUN;
                        w_all_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_all_running <= 1'b0;
            r_core_rst    <= '1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_all_running <= w_all_nxt;
            if (w_rel)
                r_core_rst[w_rel_idx] <= 1'b0;
        end
    end

    // ---------------- per-core holding slots ----------------
    for (genvar g = 0; g < N_CORES; g++) begin : g_slot
        assign w_cap[g] = ~r_core_rst[g] & (|core_en[g*TAG_W +: TAG_W]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_pending[g]   <= 1'b0;
                r_hold_data[g] <= '0;
                r_hold_tag[g]  <= '0;
            end else begin
                // A capture coinciding with a drain keeps the slot pending
                r_pending[g] <= (r_pending[g] & ~w_drain[g]) | w_cap[g];
                if (w_cap[g]) begin
                    r_hold_data[g] <= core_data[g*DATA_W +: DATA_W];
                    r_hold_tag[g]  <= core_en[g*TAG_W +: TAG_W];
                end
            end
        end
    end

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < N_CORES; k++) begin : b_scan
            int               j;
            logic [IDX_W-1:0] j_idx;
            j = int'(r_ptr) + k;
            if (j >= N_CORES)
                j = j - N_CORES;
            j_idx = IDX_W'(j);
            if (!w_found && r_pending[j_idx]) begin
                w_found = 1'b1;
                w_grant = j_idx;
            end
        end
        w_load    = ~r_out_valid | out_ready;
        w_drain   = (w_load && w_found) ? (N_CORES'(1) << w_grant) : '0;
        w_ptr_nxt = (w_grant == IDX_W'(N_CORES - 1)) ? '0 : w_grant + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_core  <= '0;
            r_ptr       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_data <= r_hold_data[w_grant];
                    r_out_tag  <= r_hold_tag[w_grant];
                    r_out_core <= w_grant;
                    r_ptr      <= w_ptr_nxt;
                end
            end
            if (|(w_cap & r_pending & ~w_drain))
                r_overflow <= 1'b1;
        end
    end

    assign core_rst    = r_core_rst;
    assign all_running = r_all_running;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign out_core    = r_out_core;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire
